// File: rtl/taxi_eth_tx_arb_pkg.sv
// taxi_eth_tx_arb_pkg: shared types and round-robin selection for the MAC TX arbiter
package taxi_eth_tx_arb_pkg;
  localparam int unsigned MAX_PORTS = 16;
  typedef enum logic {IDLE, XFER} state_t;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_sel_t;
  // First requester at or after ptr, wrapping at ports-1 back to 0
  function automatic rr_sel_t rr_select(input logic [MAX_PORTS-1:0] req, input logic [3:0] ptr,
                                        input int unsigned ports);
    rr_sel_t r;
    logic [3:0] j;
    r = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      j = 4'((32'(ptr) + i) % ports);
      if (i < ports && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/taxi_eth_tx_arb.sv
// taxi_eth_tx_arb: frame-granular round-robin share of one MAC TX stream,
// with MAC completions routed back to the source by the tid tag.
module taxi_eth_tx_arb
  import taxi_eth_tx_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ID_W  = 8,
  parameter int CPL_W = 96,
  localparam int SEL_W = $clog2(PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS*8-1:0]    s_tx_tdata,
  input  logic [PORTS-1:0]      s_tx_tvalid,
  input  logic [PORTS-1:0]      s_tx_tlast,
  input  logic [PORTS-1:0]      s_tx_tuser,
  input  logic [PORTS*ID_W-1:0] s_tx_tid,
  output logic [PORTS-1:0]      s_tx_tready,
  output logic [7:0]            m_tx_tdata,
  output logic                  m_tx_tvalid,
  output logic                  m_tx_tlast,
  output logic                  m_tx_tuser,
  output logic [ID_W-1:0]       m_tx_tid,
  input  logic                  m_tx_tready,
  input  logic [CPL_W-1:0]      s_cpl_tdata,
  input  logic [ID_W-1:0]       s_cpl_tid,
  input  logic                  s_cpl_tvalid,
  output logic                  s_cpl_tready,
  output logic [CPL_W-1:0]      m_cpl_tdata,
  output logic [ID_W-1:0]       m_cpl_tid,
  output logic [PORTS-1:0]      m_cpl_tvalid,
  input  logic [PORTS-1:0]      m_cpl_tready,
  input  logic                  cfg_enable,
  output logic                  sts_busy,
  output logic [SEL_W-1:0]      sts_grant,
  output logic                  sts_cpl_drop
);
  state_t           state_q;
  logic [SEL_W-1:0] grant_q, rr_ptr_q, rr_ptr_d, cpl_port;
  logic             busy_q, drop_q, xfer, cpl_ok;
  rr_sel_t          sel;

  assign sel      = rr_select(16'(s_tx_tvalid), 4'(rr_ptr_q), PORTS);
  assign rr_ptr_d = (32'(grant_q) == PORTS - 1) ? '0 : grant_q + 1'b1;
  assign xfer     = state_q == XFER;

  assign m_tx_tvalid = xfer && s_tx_tvalid[grant_q];
  assign m_tx_tdata  = s_tx_tdata[grant_q*8 +: 8];
  assign m_tx_tlast  = s_tx_tlast[grant_q];
  assign m_tx_tuser  = s_tx_tuser[grant_q];
  assign m_tx_tid    = {grant_q, s_tx_tid[grant_q*ID_W +: ID_W-SEL_W]};
  assign s_tx_tready = (xfer && m_tx_tready) ? PORTS'(1) << grant_q : '0;

  // Tags beyond PORTS-1 have no owner: swallow them so the MAC never stalls
  assign cpl_port     = s_cpl_tid[ID_W-1 -: SEL_W];
  assign cpl_ok       = 32'(cpl_port) < PORTS;
  assign m_cpl_tvalid = (s_cpl_tvalid && cpl_ok) ? PORTS'(1) << cpl_port : '0;
  assign s_cpl_tready = cpl_ok ? m_cpl_tready[cpl_port] : 1'b1;
  assign m_cpl_tdata  = s_cpl_tdata;
  assign m_cpl_tid    = {{SEL_W{1'b0}}, s_cpl_tid[ID_W-SEL_W-1:0]};

  assign sts_busy     = busy_q;
  assign sts_grant    = grant_q;
  assign sts_cpl_drop = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= s_cpl_tvalid && !cpl_ok;
      if (!xfer && cfg_enable && sel.found) begin
        state_q <= XFER;
        busy_q  <= 1'b1;
        grant_q <= SEL_W'(sel.idx);
      end else if (m_tx_tvalid && m_tx_tready && m_tx_tlast) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end
endmodule

// File: tb/tb_taxi_eth_tx_arb.sv
// tb_taxi_eth_tx_arb: randomized scoreboard bench; a round-robin frame model
// predicts the MAC-side beat stream and completions are predicted at issue time.
module tb_taxi_eth_tx_arb;
  localparam int P = 4;

  typedef struct packed {logic [7:0] d; logic l; logic u; logic [7:0] id;} beat_t;
  typedef struct packed {logic [3:0] v; logic [7:0] id; logic [95:0] d;} cpl_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P*8-1:0] s_tx_tdata, s_tx_tid;
  logic [P-1:0]   s_tx_tvalid, s_tx_tlast, s_tx_tuser, s_tx_tready;
  logic [7:0]     m_tx_tdata, m_tx_tid;
  logic           m_tx_tvalid, m_tx_tlast, m_tx_tuser, m_tx_tready;
  logic [95:0]    s_cpl_tdata, m_cpl_tdata;
  logic [7:0]     s_cpl_tid, m_cpl_tid;
  logic           s_cpl_tvalid, s_cpl_tready, cfg_enable, sts_busy, sts_cpl_drop;
  logic [P-1:0]   m_cpl_tvalid, m_cpl_tready;
  logic [1:0]     sts_grant;

  logic [23:0] c3_tx_tdata, c3_tx_tid;
  logic [2:0]  c3_tx_tvalid, c3_tx_tlast, c3_tx_tuser, c3_tx_tready;
  logic [7:0]  c3_m_tdata, c3_m_tid, c3_cpl_tid, c3_m_cpl_tid;
  logic        c3_m_tvalid, c3_m_tlast, c3_m_tuser, c3_cpl_tvalid, c3_cpl_tready;
  logic        c3_busy, c3_drop;
  logic [95:0] c3_m_cpl_tdata;
  logic [2:0]  c3_m_cpl_tvalid, c3_m_cpl_tready;
  logic [1:0]  c3_grant;

  taxi_eth_tx_arb #(.PORTS(P), .ID_W(8), .CPL_W(96)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tx_tdata(s_tx_tdata), .s_tx_tvalid(s_tx_tvalid), .s_tx_tlast(s_tx_tlast),
    .s_tx_tuser(s_tx_tuser), .s_tx_tid(s_tx_tid), .s_tx_tready(s_tx_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tvalid(m_tx_tvalid), .m_tx_tlast(m_tx_tlast),
    .m_tx_tuser(m_tx_tuser), .m_tx_tid(m_tx_tid), .m_tx_tready(m_tx_tready),
    .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid), .s_cpl_tvalid(s_cpl_tvalid),
    .s_cpl_tready(s_cpl_tready), .m_cpl_tdata(m_cpl_tdata), .m_cpl_tid(m_cpl_tid),
    .m_cpl_tvalid(m_cpl_tvalid), .m_cpl_tready(m_cpl_tready), .cfg_enable(cfg_enable),
    .sts_busy(sts_busy), .sts_grant(sts_grant), .sts_cpl_drop(sts_cpl_drop)
  );

  taxi_eth_tx_arb #(.PORTS(3), .ID_W(8), .CPL_W(96)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_tx_tdata(c3_tx_tdata), .s_tx_tvalid(c3_tx_tvalid), .s_tx_tlast(c3_tx_tlast),
    .s_tx_tuser(c3_tx_tuser), .s_tx_tid(c3_tx_tid), .s_tx_tready(c3_tx_tready),
    .m_tx_tdata(c3_m_tdata), .m_tx_tvalid(c3_m_tvalid), .m_tx_tlast(c3_m_tlast),
    .m_tx_tuser(c3_m_tuser), .m_tx_tid(c3_m_tid), .m_tx_tready(1'b1),
    .s_cpl_tdata(96'h0), .s_cpl_tid(c3_cpl_tid), .s_cpl_tvalid(c3_cpl_tvalid),
    .s_cpl_tready(c3_cpl_tready), .m_cpl_tdata(c3_m_cpl_tdata), .m_cpl_tid(c3_m_cpl_tid),
    .m_cpl_tvalid(c3_m_cpl_tvalid), .m_cpl_tready(c3_m_cpl_tready), .cfg_enable(1'b1),
    .sts_busy(c3_busy), .sts_grant(c3_grant), .sts_cpl_drop(c3_drop)
  );

  beat_t src[P][$];
  beat_t pend[P][$];
  beat_t exp_tx[$];
  cpl_t  exp_cpl[$];
  int    tests = 0, fails = 0, model_ptr = 0, nbeats = 0, mode = 0, cyc = 0, last_end = 0;
  int    nf[P];
  logic  en_req = 1'b1, full_rate = 1'b0, cpl_go = 1'b0, cpl_done = 1'b0, mid = 1'b0, have_end = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Queue frames per source and predict the MAC-side order by plain round robin
  task automatic gen(input int lmin, input int lmax, input int tidf);
    int left[P];
    int tot, g, len;
    logic [7:0] t;
    beat_t b;
    tot = 0;
    for (int p = 0; p < P; p++) begin
      left[p] = nf[p];
      tot += nf[p];
      for (int f = 0; f < nf[p]; f++) begin
        len = $urandom_range(lmax, lmin);
        t = (tidf < 0) ? 8'($urandom) : 8'(tidf);
        for (int i = 0; i < len; i++) begin
          b.d = 8'($urandom); b.l = (i == len - 1); b.u = 1'($urandom); b.id = t;
          src[p].push_back(b);
          pend[p].push_back(b);
        end
      end
    end
    while (tot > 0) begin
      g = -1;
      for (int k = 0; k < P; k++) if (g < 0 && left[(model_ptr + k) % P] > 0) g = (model_ptr + k) % P;
      do begin
        b = pend[g].pop_front();
        b.id = {g[1:0], b.id[5:0]};
        exp_tx.push_back(b);
      end while (!b.l);
      left[g]--;
      tot--;
      model_ptr = (g + 1) % P;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 5000 && exp_tx.size() > 0; i++) @(negedge clk);
    chk(nm, 128'(exp_tx.size()), 128'(0));
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < P; p++) begin
      if (src[p].size() > 0) begin
        b = src[p][0];
        s_tx_tvalid[p] = 1'b1; s_tx_tdata[p*8 +: 8] = b.d; s_tx_tlast[p] = b.l;
        s_tx_tuser[p] = b.u; s_tx_tid[p*8 +: 8] = b.id;
      end else begin
        s_tx_tvalid[p] = 1'b0; s_tx_tdata[p*8 +: 8] = 8'($urandom); s_tx_tlast[p] = 1'($urandom);
        s_tx_tuser[p] = 1'b0; s_tx_tid[p*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  // Source driver: advance a source only after its beat was accepted
  initial begin
    logic [P-1:0] hs;
    m_tx_tready = 1'b1; cfg_enable = 1'b1;
    c3_tx_tdata = '0; c3_tx_tid = '0; c3_tx_tvalid = '0; c3_tx_tlast = '0; c3_tx_tuser = '0;
    drive();
    forever begin
      @(negedge clk);
      hs = s_tx_tvalid & s_tx_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < P; p++) if (hs[p] && src[p].size() > 0) src[p].delete(0);
      m_tx_tready = (mode == 1) ? 1'($urandom) : (mode == 2) ? !m_tx_tready : 1'b1;
      cfg_enable  = (mode == 1) ? ($urandom_range(3, 0) != 0) : en_req;
      drive();
    end
  end

  // TX monitor
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (!rst_n) begin
      mid = 1'b0; have_end = 1'b0;
    end else begin
      if (!m_tx_tready) chk("ready_gated", 128'(s_tx_tready), 128'(0));
      if (m_tx_tvalid && m_tx_tready) begin
        nbeats++;
        if (exp_tx.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_extra_beat actual=%0h expected=none", {m_tx_tdata, m_tx_tlast, m_tx_tid});
        end else begin
          e = exp_tx.pop_front();
          chk("tx_beat", 128'({m_tx_tdata, m_tx_tlast, m_tx_tuser, m_tx_tid}), 128'(e));
          chk("tx_ready_onehot", 128'(s_tx_tready), 128'(4'(1) << e.id[7:6]));
          chk("sts_grant", 128'(sts_grant), 128'(e.id[7:6]));
          if (!mid && have_end) begin
            if (full_rate) chk("gap_exact", 128'(cyc - last_end), 128'(2));
            else chk("gap_min", 128'(cyc - last_end >= 2), 128'(1));
          end
        end
        mid = !m_tx_tlast;
        if (m_tx_tlast) begin
          last_end = cyc; have_end = 1'b1;
        end
      end
    end
  end

  // Completion monitor
  initial forever begin
    cpl_t c;
    @(negedge clk);
    if (rst_n && s_cpl_tvalid && s_cpl_tready) begin
      if (exp_cpl.size() == 0) begin
        tests++; fails++;
        $display("FAIL cpl_extra actual=%0h expected=none", m_cpl_tvalid);
      end else begin
        c = exp_cpl.pop_front();
        chk("cpl_route", 128'({m_cpl_tvalid, m_cpl_tid, m_cpl_tdata}), 128'(c));
      end
    end
  end

  // Completion stimulus
  initial begin
    logic hs;
    s_cpl_tvalid = 1'b0; s_cpl_tid = '0; s_cpl_tdata = '0; m_cpl_tready = '0;
    c3_cpl_tvalid = 1'b0; c3_cpl_tid = '0; c3_m_cpl_tready = 3'b100;
    wait (cpl_go);
    @(posedge clk); #1;
    s_cpl_tdata = {$urandom, $urandom, $urandom}; s_cpl_tid = 8'hC3; s_cpl_tvalid = 1'b1;
    m_cpl_tready = 4'b0111;
    exp_cpl.push_back('{v: 4'b1000, id: 8'h03, d: s_cpl_tdata});
    repeat (5) begin
      @(negedge clk);
      chk("cpl_stall_ready", 128'(s_cpl_tready), 128'(0));
      chk("cpl_stall_valid", 128'(m_cpl_tvalid), 128'(4'b1000));
      @(posedge clk); #1;
    end
    m_cpl_tready = 4'b1000;
    @(posedge clk); #1;
    s_cpl_tvalid = 1'b0;
    repeat (200) begin
      @(negedge clk);
      hs = s_cpl_tvalid && s_cpl_tready;
      @(posedge clk); #1;
      m_cpl_tready = 4'($urandom);
      if (hs || !s_cpl_tvalid) begin
        s_cpl_tvalid = 1'($urandom);
        if (s_cpl_tvalid) begin
          s_cpl_tdata = {$urandom, $urandom, $urandom}; s_cpl_tid = 8'($urandom);
          exp_cpl.push_back('{v: 4'(1) << s_cpl_tid[7:6], id: {2'b00, s_cpl_tid[5:0]}, d: s_cpl_tdata});
        end
      end
    end
    m_cpl_tready = '1;
    @(posedge clk); #1;
    s_cpl_tvalid = 1'b0;
    c3_cpl_tid = 8'hC0; c3_cpl_tvalid = 1'b1;
    @(negedge clk);
    chk("drop_ready", 128'(c3_cpl_tready), 128'(1));
    chk("drop_no_route", 128'(c3_m_cpl_tvalid), 128'(0));
    chk("drop_not_yet", 128'(c3_drop), 128'(0));
    @(posedge clk); #1;
    c3_cpl_tvalid = 1'b0;
    @(negedge clk);
    chk("drop_pulse", 128'(c3_drop), 128'(1));
    @(negedge clk);
    chk("drop_once", 128'(c3_drop), 128'(0));
    @(posedge clk); #1;
    c3_cpl_tid = 8'h81; c3_cpl_tvalid = 1'b1;
    @(negedge clk);
    chk("c3_route_valid", 128'({c3_m_cpl_tvalid, c3_cpl_tready, c3_m_cpl_tid}), 128'({3'b100, 1'b1, 8'h01}));
    @(posedge clk); #1;
    c3_cpl_tvalid = 1'b0;
    @(negedge clk);
    chk("c3_no_drop", 128'(c3_drop), 128'(0));
    cpl_done = 1'b1;
  end

  initial begin
    int base;
    #1;
    chk("rst_tvalid", 128'(m_tx_tvalid), 128'(0));
    chk("rst_tready", 128'(s_tx_tready), 128'(0));
    chk("rst_status", 128'({sts_busy, sts_grant, sts_cpl_drop, m_cpl_tvalid}), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    nf = '{2, 1, 1, 1}; full_rate = 1'b1; mode = 0;
    gen(10, 10, -1);
    drain("drain_fair");
    full_rate = 1'b0;
    @(posedge clk); #2;
    mode = 2; nf = '{0, 0, 1, 0};
    gen(60, 60, 8'h05);
    drain("drain_single");
    mode = 0;
    @(posedge clk); #2;
    nf = '{1, 0, 0, 1};
    gen(4, 6, -1);
    drain("drain_after_p2");
    @(posedge clk); #2;
    nf = '{1, 1, 0, 0}; base = nbeats;
    gen(8, 8, -1);
    for (int i = 0; i < 200 && nbeats < base + 2; i++) @(negedge clk);
    en_req = 1'b0;
    for (int i = 0; i < 200 && exp_tx.size() > 8; i++) @(negedge clk);
    repeat (6) begin
      @(negedge clk);
      chk("en_off_busy", 128'(sts_busy), 128'(0));
      chk("en_off_valid", 128'(m_tx_tvalid), 128'(0));
    end
    en_req = 1'b1;
    @(negedge clk);
    chk("en_on_not_yet", 128'(sts_busy), 128'(0));
    @(negedge clk);
    chk("en_on_grant", 128'({sts_busy, m_tx_tvalid}), 128'(2'b11));
    drain("drain_en");
    mode = 1; cpl_go = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #2;
      for (int p = 0; p < P; p++) nf[p] = $urandom_range(3, 0);
      gen(1, 16, -1);
      drain("drain_rand");
    end
    mode = 0;
    for (int i = 0; i < 3000 && !cpl_done; i++) @(negedge clk);
    chk("cpl_done", 128'({cpl_done, 8'(exp_cpl.size())}), 128'({1'b1, 8'd0}));
    @(posedge clk); #2;
    nf = '{0, 0, 1, 0}; base = nbeats;
    gen(60, 60, -1);
    for (int i = 0; i < 500 && nbeats < base + 20; i++) @(posedge clk);
    #2 chk("busy_mid_frame", 128'({sts_busy, sts_grant}), 128'({1'b1, 2'd2}));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx", 128'({m_tx_tvalid, s_tx_tready}), 128'(0));
    chk("arst_status", 128'({sts_busy, sts_grant}), 128'(0));
    for (int p = 0; p < P; p++) src[p].delete();
    exp_tx.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    nf = '{1, 0, 0, 1};
    gen(3, 5, -1);
    drain("drain_post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
